// File: rtl/ocp_initiator_pkg.sv
// Shared OCP encodings, bus widths and FSM states for the OCP initiator.
package ocp_initiator_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BEN_WIDTH  = 4;

    localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
    localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
    localparam logic [2:0] OCP_CMD_READ  = 3'd2;

    localparam logic [1:0] OCP_RESP_NULL = 2'd0;
    localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
    localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
    localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic resp_is_err(input logic [1:0] r);
        return (r == OCP_RESP_FAIL) || (r == OCP_RESP_ERR);
    endfunction

endpackage

// File: rtl/ocp_initiator.sv
// Single-outstanding OCP master: one client request becomes one
// OCP read or write, with a response timeout guarding against dead slaves.
module ocp_initiator
    import ocp_initiator_pkg::*;
#(
    parameter bit          WR_RESP   = 1'b1,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TMO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [BEN_WIDTH-1:0]  i_ben,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_tmo,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [DATA_WIDTH-1:0] o_MData,
    output logic [BEN_WIDTH-1:0]  o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp
);

    state_t               state_q;
    logic                 we_q;
    logic [TMO_WIDTH-1:0] cnt_q;

    logic       fin;
    logic       tmo_hit;
    logic [1:0] fin_code;

    always_comb begin
        fin = 1'b0;
        if (state_q == ST_CMD && i_SCmdAccept)
            fin = (i_SResp != OCP_RESP_NULL) || (we_q && !WR_RESP);
        else if (state_q == ST_RESP)
            fin = (i_SResp != OCP_RESP_NULL);
        // A posted write completes on accept with no response at all.
        fin_code = (i_SResp == OCP_RESP_NULL) ? OCP_RESP_DVA : i_SResp;
        tmo_hit  = (TIMEOUT != 0) && (state_q != ST_IDLE) && !fin &&
                   (cnt_q == TMO_WIDTH'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            o_tmo     <= 1'b0;
            o_rdata   <= '0;
            o_MAddr   <= '0;
            o_MCmd    <= OCP_CMD_IDLE;
            o_MData   <= '0;
            o_MByteEn <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            o_tmo  <= 1'b0;
            if (fin || tmo_hit) begin
                state_q   <= ST_IDLE;
                o_busy    <= 1'b0;
                o_done    <= 1'b1;
                o_err     <= tmo_hit || resp_is_err(fin_code);
                o_tmo     <= tmo_hit;
                o_MAddr   <= '0;
                o_MCmd    <= OCP_CMD_IDLE;
                o_MData   <= '0;
                o_MByteEn <= '0;
                if (fin && !we_q && fin_code == OCP_RESP_DVA)
                    o_rdata <= i_SData;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (i_req && (|i_ben)) begin
                            state_q   <= ST_CMD;
                            we_q      <= i_we;
                            cnt_q     <= '0;
                            o_busy    <= 1'b1;
                            o_MAddr   <= i_addr;
                            o_MCmd    <= i_we ? OCP_CMD_WRITE : OCP_CMD_READ;
                            o_MData   <= i_we ? i_wdata : '0;
                            o_MByteEn <= i_ben;
                        end else if (i_req) begin
                            o_done <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        cnt_q <= cnt_q + TMO_WIDTH'(1);
                        if (i_SCmdAccept) begin
                            state_q   <= ST_RESP;
                            o_MAddr   <= '0;
                            o_MCmd    <= OCP_CMD_IDLE;
                            o_MData   <= '0;
                            o_MByteEn <= '0;
                        end
                    end
                    ST_RESP: begin
                        cnt_q <= cnt_q + TMO_WIDTH'(1);
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ocp_initiator.sv
// Self-checking bench for ocp_initiator: directed cases plus random
// transactions scored against a transaction-level timing model.
module tb_ocp_initiator;
    import ocp_initiator_pkg::*;

    localparam int TMO   = 16;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic        req = 0, we = 0, acc = 0, sel = 0;
    logic [31:0] addr = 0, wdata = 0, sdata = 0;
    logic [3:0]  ben = 0;
    logic [1:0]  sresp = 0;

    logic        a_busy, a_done, a_err, a_tmo, b_busy, b_done, b_err, b_tmo;
    logic [31:0] a_rdata, a_maddr, a_mdata, b_rdata, b_maddr, b_mdata;
    logic [2:0]  a_mcmd, b_mcmd;
    logic [3:0]  a_mben, b_mben;

    logic        o_busy, o_done, o_err, o_tmo;
    logic [31:0] o_rdata, o_maddr, o_mdata;
    logic [2:0]  o_mcmd;
    logic [3:0]  o_mben;

    int          nassert = 0;
    int          nfail = 0;
    logic [31:0] rd_model = 0;

    ocp_initiator #(.WR_RESP(1'b1), .TIMEOUT(TMO), .TMO_WIDTH(8)) u_dut (
        .clk(clk), .nrst(nrst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_ben(ben), .o_busy(a_busy), .o_done(a_done),
        .o_err(a_err), .o_tmo(a_tmo), .o_rdata(a_rdata), .o_MAddr(a_maddr),
        .o_MCmd(a_mcmd), .o_MData(a_mdata), .o_MByteEn(a_mben),
        .i_SCmdAccept(acc), .i_SData(sdata), .i_SResp(sresp)
    );

    ocp_initiator #(.WR_RESP(1'b0), .TIMEOUT(TMO), .TMO_WIDTH(8)) u_post (
        .clk(clk), .nrst(nrst), .i_req(req), .i_we(we), .i_addr(addr),
        .i_wdata(wdata), .i_ben(ben), .o_busy(b_busy), .o_done(b_done),
        .o_err(b_err), .o_tmo(b_tmo), .o_rdata(b_rdata), .o_MAddr(b_maddr),
        .o_MCmd(b_mcmd), .o_MData(b_mdata), .o_MByteEn(b_mben),
        .i_SCmdAccept(acc), .i_SData(sdata), .i_SResp(sresp)
    );

    always_comb begin
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_err   = sel ? b_err   : a_err;
        o_tmo   = sel ? b_tmo   : a_tmo;
        o_rdata = sel ? b_rdata : a_rdata;
        o_maddr = sel ? b_maddr : a_maddr;
        o_mdata = sel ? b_mdata : a_mdata;
        o_mcmd  = sel ? b_mcmd  : a_mcmd;
        o_mben  = sel ? b_mben  : a_mben;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, {31'd0, o_busy}, 0);
        chk({tag, ".done"}, {31'd0, o_done}, 0);
        chk({tag, ".err"}, {31'd0, o_err}, 0);
        chk({tag, ".tmo"}, {31'd0, o_tmo}, 0);
        chk({tag, ".rdata"}, o_rdata, 0);
        chk({tag, ".maddr"}, o_maddr, 0);
        chk({tag, ".mdata"}, o_mdata, 0);
        chk({tag, ".mcmd"}, {29'd0, o_mcmd}, {29'd0, OCP_CMD_IDLE});
        chk({tag, ".mben"}, {28'd0, o_mben}, 0);
    endtask

    // Slave model: accepts acc_d cycles after the command appears and
    // answers rsp_d cycles after the accept edge (0 = combined).
    task automatic run_txn(input logic t_we, input logic [31:0] t_addr,
                           input logic [31:0] t_wdata, input logic [3:0] t_ben,
                           input int acc_d, input int rsp_d,
                           input logic [1:0] rsp, input logic [31:0] sd);
        int         ea, er, ec, bus_end;
        logic       pw, abort, exp_err;
        logic [1:0] code;
        logic [2:0] cmd;
        pw  = t_we && sel;
        ea  = acc_d + 2;
        er  = (rsp != OCP_RESP_NULL && (rsp_d == 0 || !pw)) ? ea + rsp_d : NEVER;
        ec  = pw ? ea : er;
        code = (pw && er != ea) ? OCP_RESP_DVA : rsp;
        abort = ec > TMO + 2;
        if (abort) ec = TMO + 2;
        bus_end = (ea < ec) ? ea : ec;
        if (t_ben == 0) begin
            ec = 1; bus_end = 1; abort = 0; code = OCP_RESP_DVA;
        end
        exp_err = abort || code == OCP_RESP_FAIL || code == OCP_RESP_ERR;
        cmd = t_we ? OCP_CMD_WRITE : OCP_CMD_READ;

        req = 1; we = t_we; addr = t_addr; wdata = t_wdata; ben = t_ben;
        acc = 0; sresp = 2'($urandom_range(0, 3)); sdata = $urandom;
        for (int j = 1; j <= ec; j++) begin
            @(negedge clk);
            if (j < ec) begin
                chk("busy", {31'd0, o_busy}, 1);
                chk("done_early", {31'd0, o_done}, 0);
            end else begin
                if (t_ben != 0 && !abort && !t_we && code == OCP_RESP_DVA)
                    rd_model = sd;
                chk("done", {31'd0, o_done}, 1);
                chk("busy_at_done", {31'd0, o_busy}, 0);
                chk("err", {31'd0, o_err}, {31'd0, exp_err});
                chk("tmo", {31'd0, o_tmo}, {31'd0, abort});
                chk("rdata", o_rdata, rd_model);
            end
            chk("mcmd", {29'd0, o_mcmd}, (j < bus_end) ? {29'd0, cmd} : 32'd0);
            chk("maddr", o_maddr, (j < bus_end) ? t_addr : 32'd0);
            chk("mben", {28'd0, o_mben}, (j < bus_end) ? {28'd0, t_ben} : 32'd0);
            chk("mdata", o_mdata, (j < bus_end && t_we) ? t_wdata : 32'd0);
            if (j < ec) begin
                req = $urandom_range(0, 1); we = $urandom_range(0, 1);
                addr = $urandom; wdata = $urandom; ben = 4'($urandom);
                acc = (j + 1 == ea);
                sresp = (j + 1 == er) ? rsp : OCP_RESP_NULL;
                sdata = (j + 1 == er) ? sd : $urandom;
            end else begin
                req = 0; acc = 0; sresp = OCP_RESP_NULL;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 0; req = 0; acc = 0; sresp = OCP_RESP_NULL;
        @(negedge clk);
        nrst = 1;
        rd_model = 0;
    endtask

    initial begin
        int ad, rd;
        logic [3:0] bn;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        nrst = 1;

        run_txn(1, 32'h0, 32'h000F_FFF0, 4'hF, 0, 1, OCP_RESP_DVA, 32'h0);
        run_txn(0, 32'h100, 32'h0, 4'hF, 3, 1, OCP_RESP_DVA, 32'hDEAD_BEEF);
        run_txn(0, 32'h104, 32'h0, 4'h3, 0, 1, OCP_RESP_ERR, 32'h1234_5678);
        run_txn(0, 32'h108, 32'h0, 4'hF, 1000, 1, OCP_RESP_DVA, 32'h0);
        @(negedge clk);
        chk("mcmd_after_tmo", {29'd0, o_mcmd}, 0);
        run_txn(1, 32'h10C, 32'h5, 4'h0, 0, 0, OCP_RESP_DVA, 32'h0);
        run_txn(0, 32'h110, 32'h0, 4'h1, 0, 0, OCP_RESP_FAIL, 32'h0);
        run_txn(0, 32'h114, 32'h0, 4'hC, 2, 0, OCP_RESP_DVA, 32'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            bn = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ad = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            rd = ($urandom_range(0, 9) == 0) ? 25 : $urandom_range(0, 3);
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, bn, ad, rd,
                    2'($urandom_range(0, 3)), $urandom);
        end

        // Reset while waiting in RESP must abort silently.
        req = 1; we = 0; addr = 32'h40; ben = 4'hF; acc = 0;
        sresp = OCP_RESP_NULL;
        @(negedge clk);
        req = 0; acc = 1;
        @(negedge clk);
        acc = 0;
        chk("in_resp_busy", {31'd0, o_busy}, 1);
        @(negedge clk);
        #2 nrst = 0;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        nrst = 1;
        rd_model = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_reset_done", {31'd0, o_done}, 0);
            chk("post_reset_busy", {31'd0, o_busy}, 0);
        end

        sel = 1;
        do_reset();
        run_txn(1, 32'h20, 32'h1, 4'hF, 0, 1, OCP_RESP_DVA, 32'h0);
        run_txn(1, 32'h24, 32'h8000_0001, 4'hF, 0, 1, OCP_RESP_DVA, 32'h0);
        run_txn(1, 32'h28, 32'h2, 4'hF, 2, 0, OCP_RESP_ERR, 32'h0);
        run_txn(0, 32'h2C, 32'h0, 4'hF, 1, 2, OCP_RESP_DVA, 32'h0BAD_CAFE);
        for (int i = 0; i < 20; i++) begin
            bn = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ad = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            rd = $urandom_range(0, 3);
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, bn, ad, rd,
                    2'($urandom_range(0, 3)), $urandom);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule

// File: doc/ocp_initiator.md
Name: ocp_initiator

Overview:
- Single-outstanding OCP bus master that turns a simple client request (req/done) into one OCP read or write transaction.
- Drives MCmd/MAddr/MData/MByteEn, holds the command until SCmdAccept, then waits for SResp and returns the read data and status.
- Sits between an internal client (debug/boot loader, test sequencer) and OCP slaves such as sim_control or memory.
- Includes a response timeout so a dead slave cannot hang the client.

Parameters:
- WR_RESP, 1, 1: writes wait for an SResp; 0: writes complete on SCmdAccept (posted).
- TIMEOUT, 255, cycles allowed in CMD+RESP before abort; 0 disables the timeout.
- TMO_WIDTH, 8, width of the timeout counter; TIMEOUT must be < 2^TMO_WIDTH.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- i_req  in  1  client request; sampled only in IDLE.
- i_we  in  1  1 = write, 0 = read.
- i_addr  in  `ADDR_WIDTH  transaction address.
- i_wdata  in  `DATA_WIDTH  write data.
- i_ben  in  `BEN_WIDTH  byte enables.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  valid with o_done; 1 = SResp ERR/FAIL or timeout.
- o_tmo  out  1  valid with o_done; 1 = timeout.
- o_rdata  out  `DATA_WIDTH  read data; updated only on a successful read response; held otherwise.
- o_MAddr  out  `ADDR_WIDTH  OCP address.
- o_MCmd  out  3  OCP command.
- o_MData  out  `DATA_WIDTH  OCP write data.
- o_MByteEn  out  `BEN_WIDTH  OCP byte enables.
- i_SCmdAccept  in  1  slave accepts the command.
- i_SData  in  `DATA_WIDTH  slave read data.
- i_SResp  in  2  slave response.

Behaviour:
- Reset (nrst low, asynchronous, any time including mid-transaction):
  - State goes to IDLE.
  - All outputs are 0: o_MCmd = `OCP_CMD_IDLE, o_MAddr/o_MData/o_MByteEn = 0, o_busy/o_done/o_err/o_tmo = 0, o_rdata = 0.
  - No o_done is generated for an aborted transaction.
- All outputs are registered.
- IDLE:
  - OCP outputs are 0 (MCmd IDLE).
  - At a posedge with i_req=1 and i_ben≠0, latch addr/wdata/ben/we; next cycle is CMD with o_MCmd = WRITE or READ.
  - i_ben=0 with i_req=1 is a no-op: no bus activity; o_done=1 next cycle with err=0, tmo=0, rdata unchanged.
- CMD:
  - Command held stable until a posedge with SCmdAccept=1.
  - At that edge:
    - SResp≠NULL (combined accept+response): complete.
    - Write with WR_RESP=0: complete as success.
    - Otherwise: go to RESP.
  - After the accept edge, OCP outputs return to 0.
- RESP:
  - MCmd IDLE; wait for a posedge with SResp≠NULL.
  - DVA: success; on a read, capture SData into o_rdata.
  - FAIL or ERR: o_err=1; o_rdata is not updated.
- Complete:
  - Next cycle: state IDLE, o_done=1 for exactly one cycle, o_err/o_tmo valid.
  - o_busy is 0 in the o_done cycle; i_req can be accepted at that cycle's edge (back-to-back issue).
  - Minimum occupancy is 2 cycles per transaction.
- Timeout:
  - Counter clears on entry to CMD and increments each cycle in CMD/RESP.
  - When it reaches TIMEOUT with no completion: force MCmd IDLE, state IDLE, o_done=1, o_err=1, o_tmo=1.
  - If completion and expiry occur at the same edge, completion wins.
- i_req asserted while busy is ignored; requests are not queued.
- SResp arriving in IDLE (stray response) is ignored.
- Client inputs may change after the accept edge; latched copies are used.

Decomposition:
- Use the existing ocp_const.vh macros (OCP_CMD_IDLE/WRITE/READ, OCP_RESP_NULL/DVA/FAIL/ERR) and the common.vh widths.
- Add the FSM state encodings (IDLE, CMD, RESP) as localparams.
- No sub-module: the FSM, timeout counter and output registers fit in one module.

Test Plan:
- Write, slave accepts in the first CMD cycle and responds DVA the next cycle:
  - Stimulus: addr 0x000, data 0x000F_FFF0, ben 0xF.
  - Required: MCmd=WRITE for 1 cycle; o_done exactly 1 cycle after the DVA edge; err=0.
- Read, slave delays SCmdAccept by 3 cycles then returns SData=0xDEAD_BEEF with DVA:
  - Required: MAddr/MCmd held stable for 4 cycles; o_rdata=0xDEAD_BEEF; err=0.
- Read returns ERR:
  - Required: o_err=1, o_tmo=0; o_rdata keeps the previous value 0xDEAD_BEEF.
- Slave never accepts, with TIMEOUT=16:
  - Required: o_done with err=1, tmo=1 exactly 17 cycles after i_req; MCmd IDLE afterwards.
- WR_RESP=0 with two back-to-back writes (0x1, 0x8000_0001) and req held high:
  - Required: second MCmd=WRITE starts the cycle after the first o_done; each write completes on accept.
- Stray SResp and reset cases:
  - i_ben=0 request gives o_done next cycle with MCmd never leaving IDLE.
  - nrst pulled low during RESP forces all outputs to 0 immediately and no o_done follows.
